// File: rtl/dot_product_pkg.sv
// Shared definitions for the dot-product feeder and its operand buffer.
package dot_product_pkg;

    localparam int ACC_N_ELEM  = 8;
    localparam int ACC_DATA_W  = 32;
    localparam int RESULT_W    = 64;
    localparam int FRAME_WORDS = 2 * ACC_N_ELEM;

    typedef enum logic [1:0] {
        C_IDLE,
        C_START,
        C_WAIT,
        C_HOLD
    } ctrl_state_t;

endpackage

// File: rtl/dot_product_operand_buffer.sv
// Assembles a frame of operand words into the A/B register bank and tracks framing errors.
module dot_product_operand_buffer
    import dot_product_pkg::*;
#(
    parameter int DATA_W = ACC_DATA_W,
    parameter int N_ELEM = ACC_N_ELEM
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    input  logic                     consume,
    output logic                     in_ready,
    output logic                     full,
    output logic [N_ELEM*DATA_W-1:0] op_a,
    output logic [N_ELEM*DATA_W-1:0] op_b,
    output logic                     frame_err
);

    localparam int WORDS    = 2 * N_ELEM;
    localparam int CNT_W    = $clog2(WORDS);
    localparam int LAST_IDX = WORDS - 1;

    logic [CNT_W-1:0]  word_cnt_reg;
    logic              full_reg;
    logic              frame_err_reg;
    logic [DATA_W-1:0] a_reg [N_ELEM];
    logic [DATA_W-1:0] b_reg [N_ELEM];
    logic              accept;
    logic              at_last;

    assign accept  = in_valid && !full_reg;
    assign at_last = (word_cnt_reg == CNT_W'(LAST_IDX));

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_reg  <= '0;
            full_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
        end else if (consume) begin
            word_cnt_reg <= '0;
            full_reg     <= 1'b0;
        end else if (accept) begin
            if (at_last) begin
                // Counter parks on the final index until the frame is consumed.
                full_reg <= 1'b1;
                if (!in_last) begin
                    frame_err_reg <= 1'b1;
                end
            end else if (in_last) begin
                word_cnt_reg  <= '0;
                frame_err_reg <= 1'b1;
            end else begin
                word_cnt_reg <= word_cnt_reg + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_bank
        always_ff @(posedge clk) begin
            if (rst) begin
                a_reg[gi] <= '0;
                b_reg[gi] <= '0;
            end else if (accept) begin
                if (word_cnt_reg == CNT_W'(gi)) begin
                    a_reg[gi] <= in_data;
                end
                if (word_cnt_reg == CNT_W'(gi + N_ELEM)) begin
                    b_reg[gi] <= in_data;
                end
            end
        end
        assign op_a[gi*DATA_W +: DATA_W] = a_reg[gi];
        assign op_b[gi*DATA_W +: DATA_W] = b_reg[gi];
    end

    assign in_ready  = !full_reg;
    assign full      = full_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: rtl/dot_product_feeder.sv
// Streams operand frames into the dot-product accelerator and returns its results.
module dot_product_feeder
    import dot_product_pkg::*;
#(
    parameter int DATA_W         = ACC_DATA_W,
    parameter int N_ELEM         = ACC_N_ELEM,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    output logic                     acc_start,
    input  logic                     acc_done,
    input  logic [RESULT_W-1:0]      acc_result,
    output logic [N_ELEM*DATA_W-1:0] op_a,
    output logic [N_ELEM*DATA_W-1:0] op_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [RESULT_W-1:0]      res_data,
    output logic                     busy,
    output logic                     frame_err,
    output logic                     timeout_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    ctrl_state_t         state_reg, state_next;
    logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
    logic                res_valid_reg, res_valid_next;
    logic [RESULT_W-1:0] res_data_reg, res_data_next;
    logic                timeout_err_reg, timeout_err_next;
    logic                full;
    logic                consume;

    dot_product_operand_buffer #(
        .DATA_W (DATA_W),
        .N_ELEM (N_ELEM)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .consume   (consume),
        .in_ready  (in_ready),
        .full      (full),
        .op_a      (op_a),
        .op_b      (op_b),
        .frame_err (frame_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= C_IDLE;
            to_cnt_reg      <= '0;
            res_valid_reg   <= 1'b0;
            res_data_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            to_cnt_reg      <= to_cnt_next;
            res_valid_reg   <= res_valid_next;
            res_data_reg    <= res_data_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        to_cnt_next      = to_cnt_reg;
        res_valid_next   = res_valid_reg;
        res_data_next    = res_data_reg;
        timeout_err_next = timeout_err_reg;
        acc_start        = 1'b0;
        consume          = 1'b0;
        case (state_reg)
            C_IDLE: begin
                if (full) begin
                    state_next = C_START;
                end
            end
            C_START: begin
                // Accelerator samples op_a/op_b at this edge, so the buffer can refill.
                acc_start   = 1'b1;
                consume     = 1'b1;
                to_cnt_next = '0;
                state_next  = C_WAIT;
            end
            C_WAIT: begin
                if (acc_done) begin
                    res_data_next  = acc_result;
                    res_valid_next = 1'b1;
                    state_next     = C_HOLD;
                end else if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_next = 1'b1;
                    state_next       = C_IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            C_HOLD: begin
                if (res_ready) begin
                    res_valid_next = 1'b0;
                    state_next     = full ? C_START : C_IDLE;
                end
            end
            default: begin
                state_next = C_IDLE;
            end
        endcase
    end

    assign res_valid   = res_valid_reg;
    assign res_data    = res_data_reg;
    assign timeout_err = timeout_err_reg;
    assign busy        = (state_reg != C_IDLE);

endmodule

// File: tb/tb_dot_product_feeder.sv
// Self-checking bench for dot_product_feeder with a behavioural accelerator alongside.
module tb_dot_product_feeder;
    import dot_product_pkg::*;

    localparam int N   = 8;
    localparam int W   = 32;
    localparam int TO  = 64;
    localparam int LAT = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic           acc_start;
    logic           acc_done;
    logic [63:0]    acc_result;
    logic [N*W-1:0] op_a;
    logic [N*W-1:0] op_b;
    logic           res_valid;
    logic           res_ready;
    logic [63:0]    res_data;
    logic           busy;
    logic           frame_err;
    logic           timeout_err;

    always #5 clk = ~clk;

    dot_product_feeder #(
        .DATA_W         (W),
        .N_ELEM         (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .acc_start   (acc_start),
        .acc_done    (acc_done),
        .acc_result  (acc_result),
        .op_a        (op_a),
        .op_b        (op_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .busy        (busy),
        .frame_err   (frame_err),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural accelerator: samples operands at start, raises done LAT cycles later.
    logic        stuck = 1'b0;
    int          acc_cnt;
    logic [63:0] acc_pending;

    function automatic logic [63:0] acc_compute(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        longint s = 0;
        for (int i = 0; i < N; i++) begin
            s += longint'($signed(a[i*W +: W])) * longint'($signed(b[i*W +: W]));
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            acc_done   <= 1'b0;
            acc_cnt    <= 0;
            acc_result <= '0;
        end else if (acc_start) begin
            acc_done    <= 1'b0;
            acc_pending <= acc_compute(op_a, op_b);
            acc_cnt     <= LAT;
        end else if (acc_cnt > 0) begin
            acc_cnt <= acc_cnt - 1;
            if (acc_cnt == 1 && !stuck) begin
                acc_done   <= 1'b1;
                acc_result <= acc_pending;
            end
        end
    end

    // Event monitor: edge indices of interesting events, sampled at the active edge.
    int   cyc = 0;
    int   start_cnt = 0;
    int   start_edge = 0;
    int   last_edge = 0;
    int   to_edge = 0;
    int   rv_count = 0;
    logic to_prev = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        to_prev <= timeout_err;
        if (acc_start) begin
            start_cnt  <= start_cnt + 1;
            start_edge <= cyc;
        end
        if (in_valid && in_ready && in_last) last_edge <= cyc;
        if (timeout_err && !to_prev) to_edge <= cyc;
        if (res_valid) rv_count <= rv_count + 1;
    end

    // Reference model: frame words in wbuf, result by plain signed arithmetic.
    logic [W-1:0] wbuf [2*N];

    function automatic logic [63:0] ref_dot();
        longint s = 0;
        for (int i = 0; i < N; i++) begin
            s += longint'($signed(wbuf[i])) * longint'($signed(wbuf[N+i]));
        end
        return s;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < 2*N; k++) wbuf[k] = $urandom;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_words(input int n, input int last_idx);
        for (int k = 0; k < n; k++) begin
            int g = 0;
            in_valid = 1'b1;
            in_data  = wbuf[k];
            in_last  = (k == last_idx);
            while (!in_ready && g < 300) begin
                tick(1);
                g++;
            end
            if (!in_ready) begin
                chk1("in_ready wait", in_ready, 1'b1);
                break;
            end
            tick(1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input string name, input logic [63:0] exp, input int hold);
        int g = 0;
        logic [63:0] got;
        while (!res_valid && g < 300) begin
            tick(1);
            g++;
        end
        chk1({name, " valid"}, res_valid, 1'b1);
        chk64({name, " data"}, res_data, exp);
        got = res_data;
        for (int h = 0; h < hold; h++) begin
            tick(1);
            chk1({name, " hold valid"}, res_valid, 1'b1);
            chk64({name, " hold data"}, res_data, exp);
        end
        res_ready = 1'b1;
        tick(1);
        res_ready = 1'b0;
        chk1({name, " drop"}, res_valid, 1'b0);
        $display("xact %s res_data=%0d expected=%0d", name, $signed(got), $signed(exp));
    endtask

    typedef struct packed {
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        logic [63:0]    exp;
    } vec_t;

    vec_t vecs [4];
    int   ma [8] = '{-3, 5, 0, 7, -1, 2, 4, -6};
    int   mb [8] = '{10, -2, 9, 1, 100, -50, 3, 0};

    task automatic load_vec(input vec_t v);
        for (int k = 0; k < N; k++) begin
            wbuf[k]   = v.a[k*W +: W];
            wbuf[N+k] = v.b[k*W +: W];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] ta, tb;
        int s0, rv0, g;

        for (int i = 0; i < N; i++) begin
            ta[i*W +: W] = W'(i + 1);
            tb[i*W +: W] = W'(i + 1);
        end
        vecs[0] = '{a: ta, b: tb, exp: 64'd204};
        ta = {N{32'hFFFF_FFFF}};
        tb = {N{32'h7FFF_FFFF}};
        vecs[1] = '{a: ta, b: tb, exp: 64'hFFFF_FFFC_0000_0008};
        ta = {N{32'h8000_0000}};
        tb = {N{32'h0000_0001}};
        vecs[2] = '{a: ta, b: tb, exp: 64'hFFFF_FFFC_0000_0000};
        for (int i = 0; i < N; i++) begin
            ta[i*W +: W] = W'(ma[i]);
            tb[i*W +: W] = W'(mb[i]);
        end
        vecs[3] = '{a: ta, b: tb, exp: -64'sd221};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0;
        tick(3);
        chk1("reset in_ready", in_ready, 1'b1);
        chk1("reset busy", busy, 1'b0);
        chk1("reset res_valid", res_valid, 1'b0);
        chk1("reset acc_start", acc_start, 1'b0);
        chk64("reset res_data", res_data, 64'd0);
        chk1("reset op_a zero", |op_a, 1'b0);
        chk1("reset op_b zero", |op_b, 1'b0);
        chk1("reset frame_err", frame_err, 1'b0);
        chk1("reset timeout_err", timeout_err, 1'b0);
        rst = 1'b0;
        tick(1);

        // Tests 1 and 2: table of known products, each sent while the feeder is idle.
        for (int v = 0; v < 4; v++) begin
            load_vec(vecs[v]);
            send_words(2*N, 2*N-1);
            get_result($sformatf("vec%0d", v), vecs[v].exp, v + 1);
            chk_int($sformatf("vec%0d start latency", v), start_edge - last_edge, 2);
            chk1($sformatf("vec%0d frame_err", v), frame_err, 1'b0);
            chk1($sformatf("vec%0d timeout_err", v), timeout_err, 1'b0);
            tick(2);
        end

        // Test 3: second frame loads while the first result is back-pressured.
        s0 = start_cnt;
        load_vec(vecs[0]);
        send_words(2*N, 2*N-1);
        for (int k = 0; k < 2*N; k++) wbuf[k] = (k < N) ? 32'd2 : 32'd3;
        send_words(2*N, 2*N-1);
        tick(3);
        chk1("overlap in_ready low", in_ready, 1'b0);
        chk1("overlap busy", busy, 1'b1);
        chk_int("overlap one start", start_cnt, s0 + 1);
        get_result("overlap1", 64'd204, 0);
        chk1("overlap back-to-back start", acc_start, 1'b1);
        get_result("overlap2", 64'd48, 2);
        tick(2);

        // Test 4: accelerator never finishes.
        stuck = 1'b1;
        rv0 = rv_count;
        load_vec(vecs[3]);
        send_words(2*N, 2*N-1);
        g = 0;
        while (!timeout_err && g < 300) begin
            tick(1);
            g++;
        end
        tick(1);
        chk1("timeout_err set", timeout_err, 1'b1);
        chk_int("timeout wait cycles", to_edge - start_edge, TO + 1);
        chk1("timeout idle", busy, 1'b0);
        chk_int("timeout no res_valid", rv_count, rv0);
        stuck = 1'b0;
        load_vec(vecs[1]);
        send_words(2*N, 2*N-1);
        get_result("after_timeout", vecs[1].exp, 1);
        chk1("timeout_err sticky", timeout_err, 1'b1);
        tick(2);

        // Test 5: early in_last drops the partial frame.
        chk1("pre-frame frame_err", frame_err, 1'b0);
        s0 = start_cnt;
        fill_random();
        send_words(5, 4);
        chk1("early last frame_err", frame_err, 1'b1);
        tick(10);
        chk_int("early last no start", start_cnt, s0);
        chk1("early last idle", busy, 1'b0);
        chk1("early last in_ready", in_ready, 1'b1);
        fill_random();
        send_words(2*N, 2*N-1);
        get_result("after_early_last", ref_dot(), 0);
        tick(2);

        // Test 6: reset during C_WAIT.
        s0 = start_cnt;
        load_vec(vecs[0]);
        send_words(2*N, 2*N-1);
        g = 0;
        while (start_cnt == s0 && g < 50) begin
            tick(1);
            g++;
        end
        tick(2);
        chk1("pre-reset busy", busy, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk1("mid rst busy", busy, 1'b0);
        chk1("mid rst res_valid", res_valid, 1'b0);
        chk64("mid rst res_data", res_data, 64'd0);
        chk1("mid rst op_a zero", |op_a, 1'b0);
        chk1("mid rst op_b zero", |op_b, 1'b0);
        chk1("mid rst errors", frame_err | timeout_err, 1'b0);
        chk1("mid rst in_ready", in_ready, 1'b1);
        rv0 = rv_count;
        tick(20);
        chk_int("mid rst no stale result", rv_count, rv0);

        // Missing in_last: frame is still used, but flagged.
        load_vec(vecs[2]);
        send_words(2*N, -1);
        chk1("missing last frame_err", frame_err, 1'b1);
        get_result("missing_last", vecs[2].exp, 0);
        load_vec(vecs[3]);
        send_words(2*N, 2*N-1);
        get_result("after_reset", vecs[3].exp, 1);

        // Randomised frames against the reference model.
        for (int r = 0; r < 12; r++) begin
            fill_random();
            send_words(2*N, 2*N-1);
            get_result($sformatf("rand%0d", r), ref_dot(), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
